m_req_tile_decoder: RTL
=======================

# m_req_tile_decoder

Multi-port, parametrised pre-decoder for the Matrix Load Store Unit (MLSU). It arbitrates `NUM_PORTS` matrix load/store requesters round-robin and latches the granted request. It then expands that request into one pre-decoded row/column request per tile slice, held in a `DEPTH`-entry output queue. It sits between the MLSU request issue stage and the downstream address/beat generator, adds a 2-D strided mode and a flush, and does not require the requester to hold `req_i` stable after acceptance.

## Interface
Parameters:
- `MLEN`, 256: matrix length in bits; sets the tile-counter width.
- `NUM_PORTS`, 2: number of requester ports (≥1).
- `DEPTH`, 2: output queue depth (≥1).
- `mlsu_init_req_t`, logic: input request type (`reqId`, `mop`, `baseAddr`, `sew`, `md`, `stride`, `vl`, `tile`, `isLoad`, `vm`).
- `mlsu_predec_req_t`, logic: output type; adds `mode` (one-hot), `tileIdx`, `isLast`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `req_valid_i`, in, `NUM_PORTS`: per-port request valid.
- `req_ready_o`, out, `NUM_PORTS`: per-port acceptance, one-hot at most.
- `req_i`, in, `NUM_PORTS` x `mlsu_init_req_t`: per-port request.
- `flush_i`, in, 1: abort the current expansion and empty the queue.
- `preDec_req_valid_o`, out, 1: queue head valid.
- `preDec_req_ready_i`, in, 1: downstream ready.
- `preDec_req_o`, out, `mlsu_predec_req_t`: queue head.
- `busy_o`, out, 1: FSM not in `S_IDLE` or queue non-empty.
- `err_o`, out, 1: one-cycle pulse when a request with an illegal `mop` is accepted.

## Operation
- FSM states: `S_IDLE`, `S_PRE_DEC`.
- **`S_IDLE`:**
  - Grant the first valid port at or after `rr_ptr`; pulse `req_ready_o[g]` in the same cycle.
  - Latch the request, set `iter_addr = baseAddr << 1`, `tile_cnt = tile`, `tile_idx = 0`, and set `rr_ptr = (g+1) mod NUM_PORTS`.
  - Go to `S_PRE_DEC` unless the request is degenerate:
    - `tile == 0`: accepted and dropped, no output, stay in `S_IDLE`.
    - `mop == 3`: accepted and dropped, `err_o` pulses the next cycle, stay in `S_IDLE`.
- **`S_PRE_DEC`:**
  - `enq_valid = 1`.
  - Each enq fire emits the latched fields with `baseAddr = iter_addr`, `mode = 1 << mop`, `tileIdx = tile_idx`, `isLast = (tile_cnt == 1)`.
  - On each fire, update `tile_cnt--` and `tile_idx++`.
  - On the fire with `tile_cnt == 1`, return to `S_IDLE`.
- Address step per fire:
  - `mop` 0 (row-major): `+ (1 << sew)`.
  - `mop` 1 (column-major): `+ stride`.
  - `mop` 2 (2-D strided): `+ (stride << sew)`.
- Arithmetic:
  - `iter_addr` is ELEN wide and wraps modulo 2^ELEN, with no overflow flag.
  - `tile_cnt` and `tile_idx` are `clog2(MLEN+1)` bits wide.
- `flush_i` has priority over everything:
  - Next cycle: FSM in `S_IDLE`, queue empty, `rr_ptr` kept.
  - `req_ready_o = 0` in the flush cycle.
  - An enq in the flush cycle is discarded.
- The queue is first-in first-out and registered. Enq to a full queue is allowed in the same cycle as a deq.

## Timing
- Reset values: `req_ready_o = 0`, `preDec_req_valid_o = 0`, `preDec_req_o = 0`, `busy_o = 0`, `err_o = 0`, `rr_ptr = 0`, state `S_IDLE`.
- Latency: from acceptance at cycle t, the first enq happens at t+1 and the first `preDec_req_valid_o` appears at t+2.
- Throughput: a `tile = N` request occupies N+1 cycles with no back-pressure. There is one idle bubble between consecutive requests.
- `req_ready_o` is combinational from `req_valid_i`, `rr_ptr` and the state. It is never asserted outside `S_IDLE`.
- With the queue full and the head stalled, `iter_addr` and `tile_cnt` hold.
- `preDec_req_o` must be stable while valid and not ready.

## Structure
- `mlsu_pkg` holds:
  - `m_mode_oh_e`;
  - the `mop` encodings (`MOP_ROW = 0`, `MOP_COL = 1`, `MOP_2D = 2`);
  - the `mlsu_predec_req_t` field additions (`tileIdx`, `isLast`).
- The `riva_pkg` `elen_t` type is used for addresses.
- Reuse `QueueFlow` (`T`, `DEPTH`) for the output queue, with a flush clear added through a synchronous-reset OR (`rst_i | flush_i`).
- The round-robin arbiter is inline; no separate sub-module.

## Test plan
- **Row-major:** port 0, `mop = 0`, `baseAddr = 0x100`, `sew = 2`, `tile = 3`, ready held high.
  - Outputs: `baseAddr` 0x200, 0x204, 0x208; `tileIdx` 0, 1, 2; `isLast` only on the third.
  - Timing: first valid 2 cycles after accept.
- **Column-major / 2-D with back-pressure:** `mop = 1`, `stride = 0x40`, `tile = 4`, ready toggled 1010…
  - Addresses: 0x200, 0x240, 0x280, 0x2C0, with no duplicates or drops.
  - `mop = 2`, `sew = 1`: step 0x80.
- **Arbitration:** both ports valid continuously, `tile = 1` each.
  - Grants alternate 0, 1, 0, 1 and `reqId` is interleaved accordingly.
  - With port 1 only valid after a port 0 grant, port 1 is granted.
- **Degenerate requests:**
  - `tile = 0`: accepted, no output, `busy_o` stays 0.
  - `mop = 3`: accepted, `err_o` pulses for exactly 1 cycle, no output.
- **Flush:** assert `flush_i` mid-expansion (tile 8, after 3 fires, queue full).
  - Next cycle: `preDec_req_valid_o = 0` and `busy_o = 0`.
  - A new request is then accepted normally.
- **Reset mid-operation:** assert `rst_i` during `S_PRE_DEC`.
  - All outputs return to their reset values the next cycle, and `rr_ptr = 0`.

Source files
------------

// File: rtl/m_req_tile_decoder_pkg.sv
// Shared types, encodings and helpers for the MLSU request tile pre-decoder.
package m_req_tile_decoder_pkg;

  localparam int ELEN     = 32;
  localparam int MLEN_DEF = 256;
  localparam int TILE_W   = $clog2(MLEN_DEF + 1);

  typedef logic [ELEN-1:0] elen_t;

  localparam logic [1:0] MOP_ROW = 2'd0;
  localparam logic [1:0] MOP_COL = 2'd1;
  localparam logic [1:0] MOP_2D  = 2'd2;
  localparam logic [1:0] MOP_ILL = 2'd3;

  typedef enum logic [2:0] {
    MODE_NONE = 3'b000,
    MODE_ROW  = 3'b001,
    MODE_COL  = 3'b010,
    MODE_2D   = 3'b100
  } m_mode_oh_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRE_DEC = 1'b1
  } predec_state_e;

  typedef struct packed {
    logic [3:0]        reqId;
    logic [1:0]        mop;
    elen_t             baseAddr;
    logic [1:0]        sew;
    logic [2:0]        md;
    elen_t             stride;
    logic [8:0]        vl;
    logic [TILE_W-1:0] tile;
    logic              isLoad;
    logic              vm;
  } mlsu_init_req_t;

  typedef struct packed {
    logic [3:0]        reqId;
    logic [1:0]        mop;
    elen_t             baseAddr;
    logic [1:0]        sew;
    logic [2:0]        md;
    elen_t             stride;
    logic [8:0]        vl;
    logic [TILE_W-1:0] tile;
    logic              isLoad;
    logic              vm;
    m_mode_oh_e        mode;
    logic [TILE_W-1:0] tileIdx;
    logic              isLast;
  } mlsu_predec_req_t;

  // Address increment applied after every emitted tile slice.
  function automatic elen_t addr_step(input logic [1:0] mop, input logic [1:0] sew,
                                      input elen_t stride);
    case (mop)
      MOP_ROW: return elen_t'(1) << sew;
      MOP_COL: return stride;
      default: return stride << sew;
    endcase
  endfunction

  // One-hot mode tag for a legal mop; illegal mops never reach the queue.
  function automatic m_mode_oh_e mop_to_mode(input logic [1:0] mop);
    case (mop)
      MOP_ROW: return MODE_ROW;
      MOP_COL: return MODE_COL;
      MOP_2D:  return MODE_2D;
      default: return MODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/m_req_tile_decoder_if.sv
// Requester-side and downstream-side handshake bundle of the tile pre-decoder.
interface m_req_tile_decoder_if #(
  parameter int NUM_PORTS = 2
);
  import m_req_tile_decoder_pkg::*;

  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] req_ready;
  mlsu_init_req_t       req [NUM_PORTS];
  logic                 flush;
  logic                 preDec_req_valid;
  logic                 preDec_req_ready;
  mlsu_predec_req_t     preDec_req;
  logic                 busy;
  logic                 err;

  modport master (
    output req_valid, req, flush, preDec_req_ready,
    input  req_ready, preDec_req_valid, preDec_req, busy, err
  );

  modport slave (
    input  req_valid, req, flush, preDec_req_ready,
    output req_ready, preDec_req_valid, preDec_req, busy, err
  );

endinterface

// File: rtl/m_req_tile_decoder_queue.sv
// Registered first-in first-out queue; a full queue still accepts when the head leaves.
module QueueFlow #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enq_valid_i,
  output logic enq_ready_o,
  input  T     enq_data_i,
  output logic deq_valid_o,
  input  logic deq_ready_i,
  output T     deq_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             enq_fire;
  logic             deq_fire;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count_q == CNT_W'(DEPTH));
  assign deq_valid_o = (count_q != '0);
  assign enq_ready_o = !full || deq_ready_i;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign deq_fire    = deq_valid_o && deq_ready_i;
  assign deq_data_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; reset also serves as the flush clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (enq_fire) begin
        mem_q[wr_ptr_q] <= enq_data_i;
        wr_ptr_q        <= bump(wr_ptr_q);
      end
      if (deq_fire) begin
        rd_ptr_q <= bump(rd_ptr_q);
      end
      if (enq_fire && !deq_fire) begin
        count_q <= count_q + 1'b1;
      end else if (!enq_fire && deq_fire) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_req_tile_decoder.sv
// MLSU request pre-decoder: round-robin grant, then one queued request per tile slice.
module m_req_tile_decoder #(
  parameter int MLEN      = 256,
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  m_req_tile_decoder_if.slave  bus
);
  import m_req_tile_decoder_pkg::*;

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(MLEN + 1);

  predec_state_e    state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  mlsu_init_req_t   lat_q, lat_d;
  elen_t            iter_addr_q, iter_addr_d;
  logic [CNT_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [CNT_W-1:0] tile_idx_q, tile_idx_d;
  logic             err_q, err_d;

  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] arb_cand;
  logic             accept;
  logic             enq_valid;
  logic             enq_ready;
  mlsu_predec_req_t enq_data;
  mlsu_init_req_t   granted_req;

  // Pick the first valid port at or after the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      arb_cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
      if (!grant_found && bus.req_valid[arb_cand]) begin
        grant_found = 1'b1;
        grant_idx   = arb_cand;
      end
    end
  end

  // Acceptance only while idle, never during flush or reset.
  always_comb begin
    bus.req_ready = '0;
    accept        = 1'b0;
    if (state_q == S_IDLE && grant_found && !bus.flush && !rst_i) begin
      bus.req_ready[grant_idx] = 1'b1;
      accept                   = 1'b1;
    end
  end

  assign granted_req = bus.req[grant_idx];

  // Next-state logic: latch on grant, then walk the tile slices one per enqueue.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lat_d       = lat_q;
    iter_addr_d = iter_addr_q;
    tile_cnt_d  = tile_cnt_q;
    tile_idx_d  = tile_idx_q;
    err_d       = 1'b0;
    enq_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_d       = granted_req;
          iter_addr_d = granted_req.baseAddr << 1;
          tile_cnt_d  = CNT_W'(granted_req.tile);
          tile_idx_d  = '0;
          rr_ptr_d    = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
          if (granted_req.mop == MOP_ILL) begin
            err_d = 1'b1;
          end else if (granted_req.tile != '0) begin
            state_d = S_PRE_DEC;
          end
        end
      end
      S_PRE_DEC: begin
        enq_valid = !bus.flush;
        if (enq_ready) begin
          iter_addr_d = iter_addr_q + addr_step(lat_q.mop, lat_q.sew, lat_q.stride);
          tile_cnt_d  = tile_cnt_q - CNT_W'(1);
          tile_idx_d  = tile_idx_q + CNT_W'(1);
          if (tile_cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end
  end

  // Build the pre-decoded slice from the latched request and iteration state.
  always_comb begin
    enq_data          = '0;
    enq_data.reqId    = lat_q.reqId;
    enq_data.mop      = lat_q.mop;
    enq_data.baseAddr = iter_addr_q;
    enq_data.sew      = lat_q.sew;
    enq_data.md       = lat_q.md;
    enq_data.stride   = lat_q.stride;
    enq_data.vl       = lat_q.vl;
    enq_data.tile     = lat_q.tile;
    enq_data.isLoad   = lat_q.isLoad;
    enq_data.vm       = lat_q.vm;
    enq_data.mode     = mop_to_mode(lat_q.mop);
    enq_data.tileIdx  = TILE_W'(tile_idx_q);
    enq_data.isLast   = (tile_cnt_q == CNT_W'(1));
  end

  // State register and iteration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      lat_q       <= '0;
      iter_addr_q <= '0;
      tile_cnt_q  <= '0;
      tile_idx_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_q       <= lat_d;
      iter_addr_q <= iter_addr_d;
      tile_cnt_q  <= tile_cnt_d;
      tile_idx_q  <= tile_idx_d;
      err_q       <= err_d;
    end
  end

  QueueFlow #(
    .T     (mlsu_predec_req_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i | bus.flush),
    .enq_valid_i (enq_valid),
    .enq_ready_o (enq_ready),
    .enq_data_i  (enq_data),
    .deq_valid_o (bus.preDec_req_valid),
    .deq_ready_i (bus.preDec_req_ready),
    .deq_data_o  (bus.preDec_req)
  );

  assign bus.busy = (state_q != S_IDLE) || bus.preDec_req_valid;
  assign bus.err  = err_q;

endmodule
